// File: rtl/ifsram_w.sv
// Write side of the input-feature SRAM: fills the 4-row ifmap ring from a valid/ready
// stream, one row of cfg_window*3*cfg_atlchin words per ring slot.
module ifsram_w #(
   parameter int TBITS              = 64,
   parameter int TBYTE              = 8,
   parameter int IFMAP_SRAM_ADDBITS = 11
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          if_write_start,
   output logic                          if_write_busy,
   output logic                          if_write_done,
   input  logic [7:0]                    cfg_window,
   input  logic [4:0]                    cfg_atlchin,
   input  logic [2:0]                    cfg_row_num,
   input  logic                          row_ptr_clr,
   output logic [1:0]                    if_write_row_ptr,
   input  logic [TBITS-1:0]              isif_data,
   input  logic                          isif_valid,
   output logic                          isif_ready,
   output logic                          cen_write_ifsram,
   output logic                          wen_write_ifsram,
   output logic [IFMAP_SRAM_ADDBITS-1:0] addr_write_ifsram,
   output logic [TBITS-1:0]              data_write_ifsram
);

   // 255 * 3 * 31 = 23715 words per row fits in 15 bits
   localparam int RWB = 15;
   localparam int AB  = IFMAP_SRAM_ADDBITS;

   if (TBYTE * 8 != TBITS) begin : g_width_check
      $error("TBITS must equal TBYTE*8");
   end

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t           state_q, state_d;
   logic [RWB-1:0]   row_words;
   logic [RWB-1:0]   word_cnt;
   logic [2:0]       rows_left;
   logic [AB-1:0]    row_base;
   logic [RWB+1:0]   base_full;
   logic             accept;
   logic             last_word;

   assign if_write_busy = (state_q != IDLE);
   assign if_write_done = (state_q == DONE);
   assign isif_ready    = (state_q == WRITE);
   assign accept        = isif_valid && isif_ready;
   assign last_word     = (word_cnt == row_words - RWB'(1));
   assign base_full     = (RWB+2)'(if_write_row_ptr) * (RWB+2)'(row_words);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (if_write_start) state_d = LOAD;
         LOAD: begin
            if (row_words == '0 || rows_left == '0) state_d = DONE;
            else                                    state_d = WRITE;
         end
         // End of a row re-enters LOAD, which is the one-cycle ready bubble
         WRITE: begin
            if (accept && last_word) state_d = (rows_left == 3'd1) ? DONE : LOAD;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_words         <= '0;
         word_cnt          <= '0;
         rows_left         <= '0;
         row_base          <= '0;
         if_write_row_ptr  <= '0;
         cen_write_ifsram  <= 1'b1;
         wen_write_ifsram  <= 1'b1;
         addr_write_ifsram <= '0;
         data_write_ifsram <= '0;
      end else begin
         cen_write_ifsram  <= 1'b1;
         wen_write_ifsram  <= 1'b1;
         addr_write_ifsram <= '0;
         case (state_q)
            IDLE: begin
               if (row_ptr_clr) if_write_row_ptr <= '0;
               if (if_write_start) begin
                  row_words <= RWB'(cfg_window) * RWB'(3) * RWB'(cfg_atlchin);
                  rows_left <= cfg_row_num;
               end
            end
            LOAD: begin
               row_base <= base_full[AB-1:0];
               word_cnt <= '0;
            end
            WRITE: begin
               if (accept) begin
                  cen_write_ifsram  <= 1'b0;
                  wen_write_ifsram  <= 1'b0;
                  addr_write_ifsram <= row_base + word_cnt[AB-1:0];
                  data_write_ifsram <= isif_data;
                  if (last_word) begin
                     word_cnt         <= '0;
                     if_write_row_ptr <= if_write_row_ptr + 2'd1;
                     rows_left        <= rows_left - 3'd1;
                  end else begin
                     word_cnt <= word_cnt + RWB'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
